// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle sequencer and the datapath muxes it steers.
// States, instruction classes, opcode/funct values and select encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB_ALU,
        ST_WB_MEM,
        ST_BRANCH,
        ST_JUMP,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_IMM,
        CLS_LW,
        CLS_SW,
        CLS_BRANCH,
        CLS_J,
        CLS_JAL,
        CLS_ILLEGAL
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20, F_SUB  = 6'h22, F_AND  = 6'h24, F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2a, F_SLTU = 6'h2b;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00, PC_SRC_BRANCH = 2'b01, PC_SRC_JUMP = 2'b10;
    localparam logic [1:0] WB_SEL_ALU = 2'b00, WB_SEL_MEM    = 2'b01, WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] DST_RT     = 2'b00, DST_RD        = 2'b01, DST_RA      = 2'b10;
    localparam logic [1:0] ALU_PC4    = 2'b00, ALU_BRANCH    = 2'b01, ALU_EXEC    = 2'b10;
    localparam logic [1:0] ERR_NONE   = 2'b00, ERR_ILLEGAL   = 2'b01, ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: {opcode, funct} -> class, legal.
// Zero latency; no handshake.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output logic         legal
);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU,
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: cls = CLS_RTYPE;
                    default:                                       cls = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: cls = CLS_IMM;
            OP_LW:                                               cls = CLS_LW;
            OP_SW:                                               cls = CLS_SW;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:                    cls = CLS_BRANCH;
            OP_J:                                                cls = CLS_J;
            OP_JAL:                                              cls = CLS_JAL;
            default:                                             cls = CLS_ILLEGAL;
        endcase
        legal = (cls != CLS_ILLEGAL);
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control FSM sharing one memory port and one ALU across instruction phases.
// Moore outputs; memory strobes qualified by mem_ready in the same cycle; halts on timeout/illegal.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             cond_true,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             ir_load,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic [1:0]       alu_phase,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic [1:0]       dst_sel,
    output logic             instr_done,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired
);

    state_t       state;
    logic [7:0]   wait_cnt;
    instr_class_t cls;
    logic         legal;
    logic         mem_phase;
    logic         wait_cyc;
    logic         timeout;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (cls),
        .legal  (legal)
    );

    assign mem_phase = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);
    assign wait_cyc  = mem_phase && !mem_ready;
    // The limit is only acted on when the reply is still missing; a reply in that cycle wins.
    assign timeout   = wait_cyc && (wait_cnt == 8'(MEM_TIMEOUT));
    assign halted    = (state == ST_HALT);

    always_comb begin
        pc_en      = 1'b0;
        pc_src     = PC_SRC_SEQ;
        ir_load    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        alu_phase  = ALU_PC4;
        reg_we     = 1'b0;
        wb_sel     = WB_SEL_ALU;
        dst_sel    = DST_RT;
        instr_done = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ready;
                pc_en   = mem_ready;
            end
            ST_DECODE:   alu_phase = ALU_BRANCH;
            ST_EXEC:     alu_phase = ALU_EXEC;
            ST_MEM_ADDR: alu_phase = ALU_EXEC;
            ST_MEM_RD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
            end
            ST_MEM_WR: begin
                mem_req    = 1'b1;
                addr_sel   = 1'b1;
                mem_we     = 1'b1;
                instr_done = mem_ready;
            end
            ST_WB_ALU: begin
                reg_we     = 1'b1;
                dst_sel    = (cls == CLS_RTYPE) ? DST_RD : DST_RT;
                instr_done = 1'b1;
            end
            ST_WB_MEM: begin
                reg_we     = 1'b1;
                wb_sel     = WB_SEL_MEM;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                alu_phase  = ALU_EXEC;
                pc_src     = PC_SRC_BRANCH;
                pc_en      = cond_true;
                instr_done = 1'b1;
            end
            ST_JUMP: begin
                pc_en      = 1'b1;
                pc_src     = PC_SRC_JUMP;
                instr_done = 1'b1;
                if (cls == CLS_JAL) begin
                    reg_we  = 1'b1;
                    wb_sel  = WB_SEL_PC4;
                    dst_sel = DST_RA;
                end
            end
            default: ;
        endcase
        // Strobes drop the instant reset asserts, even mid-request.
        if (!rst_n) begin
            pc_en      = 1'b0;
            ir_load    = 1'b0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            addr_sel   = 1'b0;
            reg_we     = 1'b0;
            instr_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            wait_cnt <= '0;
            err_code <= ERR_NONE;
            retired  <= '0;
        end else begin
            if (instr_done)
                retired <= retired + CNT_W'(1);
            wait_cnt <= wait_cyc ? wait_cnt + 8'd1 : 8'd0;
            case (state)
                ST_FETCH, ST_MEM_RD, ST_MEM_WR: begin
                    if (mem_ready) begin
                        case (state)
                            ST_FETCH:  state <= ST_DECODE;
                            ST_MEM_RD: state <= ST_WB_MEM;
                            default:   state <= ST_FETCH;
                        endcase
                    end else if (timeout) begin
                        state    <= ST_HALT;
                        err_code <= ERR_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    if (!legal) begin
                        state    <= ST_HALT;
                        err_code <= ERR_ILLEGAL;
                    end else begin
                        case (cls)
                            CLS_RTYPE, CLS_IMM: state <= ST_EXEC;
                            CLS_LW, CLS_SW:     state <= ST_MEM_ADDR;
                            CLS_BRANCH:         state <= ST_BRANCH;
                            default:            state <= ST_JUMP;
                        endcase
                    end
                end
                ST_EXEC:     state <= ST_WB_ALU;
                ST_MEM_ADDR: state <= (cls == CLS_SW) ? ST_MEM_WR : ST_MEM_RD;
                ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP: state <= ST_FETCH;
                default:     state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized scoreboard bench: the driver pushes expected per-instruction outcomes,
// a negedge monitor pops them on instr_done / halt entry.
module tb_mc_sequencer;

    localparam int TMO = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    opcode = '0;
    logic [5:0]    funct = '0;
    logic          cond_true = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_en, ir_load, mem_req, mem_we, addr_sel, reg_we, instr_done, halted;
    logic [1:0]    pc_src, alu_phase, wb_sel, dst_sel, err_code;
    logic [CW-1:0] retired;

    mc_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .cond_true(cond_true), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_src(pc_src), .ir_load(ir_load), .mem_req(mem_req),
        .mem_we(mem_we), .addr_sel(addr_sel), .alu_phase(alu_phase), .reg_we(reg_we),
        .wb_sel(wb_sel), .dst_sel(dst_sel), .instr_done(instr_done), .halted(halted),
        .err_code(err_code), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int halt, lat, err, reg_we, wb_sel, dst_sel, pc_en, pc_src, mem_we, alu, ret;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0, bad = 0;
    int   ev_cnt = 0, issued = 0, model_ret = 0;

    bit [5:0] r_functs [14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                                6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    bit [5:0] i_ops    [6]  = '{6'h08, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e};
    bit [5:0] b_ops    [4]  = '{6'h04, 6'h05, 6'h06, 6'h07};

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // 0 R-type, 1 immediate, 2 lw, 3 sw, 4 branch, 5 j, 6 jal, 7 illegal
    function automatic int classify(input bit [5:0] op, input bit [5:0] fn);
        if (op == 6'h00) begin
            foreach (r_functs[i]) if (r_functs[i] == fn) return 0;
            return 7;
        end
        foreach (i_ops[i]) if (i_ops[i] == op) return 1;
        foreach (b_ops[i]) if (b_ops[i] == op) return 4;
        if (op == 6'h23) return 2;
        if (op == 6'h2b) return 3;
        if (op == 6'h02) return 5;
        if (op == 6'h03) return 6;
        return 7;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic noise();
        return logic'($urandom_range(0, 1));
    endfunction

    // Answer one memory request after w unanswered cycles; checks the request stays steady.
    task automatic serve(input int w, input int exp_addr, input string tag);
        int g = 0;
        while (!mem_req && !halted && g < 20) begin
            mem_ready = noise();
            step();
            g++;
        end
        mem_ready = 1'b0;
        if (!mem_req) return;
        for (int i = 0; i <= w; i++) begin
            if (!mem_req) break;
            check({tag, "_addr_sel"}, int'(addr_sel), exp_addr);
            mem_ready = (i == w);
            step();
        end
        mem_ready = 1'b0;
    endtask

    task automatic issue(input bit [5:0] op, input bit [5:0] fn, input bit cond,
                         input int fw, input int dw);
        exp_t e;
        int   c = classify(op, fn);
        bit   mem = (c == 2) || (c == 3);
        int   g = 0;
        opcode = op;
        funct = fn;
        cond_true = cond;
        e = '{default: 0};
        e.ret = model_ret;
        if (fw > TMO) begin
            e.halt = 1; e.err = 2; e.lat = TMO + 1;
        end else if (c == 7) begin
            e.halt = 1; e.err = 1; e.lat = fw + 2;
        end else if (mem && dw > TMO) begin
            e.halt = 1; e.err = 2; e.lat = fw + TMO + 4;
        end else begin
            case (c)
                0: begin e.lat = 4; e.reg_we = 1; e.dst_sel = 1; end
                1: begin e.lat = 4; e.reg_we = 1; end
                2: begin e.lat = 5; e.reg_we = 1; e.wb_sel = 1; end
                3: begin e.lat = 4; e.mem_we = 1; end
                4: begin e.lat = 3; e.pc_en = int'(cond); e.pc_src = 1; e.alu = 2; end
                5: begin e.lat = 3; e.pc_en = 1; e.pc_src = 2; end
                default: begin
                    e.lat = 3; e.pc_en = 1; e.pc_src = 2;
                    e.reg_we = 1; e.wb_sel = 2; e.dst_sel = 2;
                end
            endcase
            e.lat += fw + (mem ? dw : 0);
            model_ret = (model_ret + 1) % (1 << CW);
        end
        exp_q.push_back(e);
        issued++;
        serve(fw, 0, "fetch");
        if (mem && fw <= TMO) serve(dw, 1, "data");
        while (ev_cnt < issued && g < 60) begin
            mem_ready = mem_req ? 1'b0 : noise();
            step();
            g++;
        end
        mem_ready = 1'b0;
        check("instr_event_seen", int'(ev_cnt >= issued), 1);
    endtask

    task automatic do_reset();
        repeat (3) begin
            mem_ready = noise();
            step();
        end
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mem_req", int'(mem_req), 0);
        step();
        check("rst_halted", int'(halted), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_retired", int'(retired), 0);
        check("rst_enables", int'({pc_en, ir_load, reg_we, mem_we, addr_sel, instr_done}), 0);
        exp_q.delete();
        issued = 0;
        ev_cnt = 0;
        model_ret = 0;
        rst_n = 1'b1;
        #1;
        check("release_mem_req", int'(mem_req), 1);
    endtask

    initial begin : monitor
        int   cyc = 0;
        bit   last_h = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc = 0;
                last_h = 0;
                continue;
            end
            if (halted) begin
                if (!last_h) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_halt", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("halt_expected", 1, e.halt);
                        check("halt_err_code", int'(err_code), e.err);
                        check("halt_latency", cyc, e.lat);
                        check("halt_retired", int'(retired), e.ret);
                    end
                    ev_cnt++;
                end else begin
                    check("halt_quiet", int'({mem_req, pc_en, reg_we, ir_load, instr_done}), 0);
                end
                last_h = 1;
                continue;
            end
            cyc++;
            if (instr_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_not_halt", 0, e.halt);
                    check("latency", cyc, e.lat);
                    check("reg_we", int'(reg_we), e.reg_we);
                    check("wb_sel", int'(wb_sel), e.wb_sel);
                    check("dst_sel", int'(dst_sel), e.dst_sel);
                    check("pc_en", int'(pc_en), e.pc_en);
                    check("pc_src", int'(pc_src), e.pc_src);
                    check("mem_we", int'(mem_we), e.mem_we);
                    check("alu_phase", int'(alu_phase), e.alu);
                    check("retired", int'(retired), e.ret);
                end
                cyc = 0;
                ev_cnt++;
            end
        end
    end

    initial begin : driver
        int c;
        bit [5:0] op, fn;
        do_reset();
        issue(6'h00, 6'h20, 1'b0, 0, 0);   // add $3,$1,$2
        issue(6'h23, 6'h00, 1'b0, 0, 3);   // lw with 3 wait cycles
        issue(6'h2b, 6'h00, 1'b0, 0, 0);
        issue(6'h04, 6'h00, 1'b0, 0, 0);
        issue(6'h04, 6'h00, 1'b1, 0, 0);
        issue(6'h03, 6'h00, 1'b0, 0, 0);
        issue(6'h02, 6'h00, 1'b1, 1, 0);
        for (int n = 0; n < 40; n++) begin
            c = $urandom_range(0, 6);
            fn = 6'($urandom_range(0, 63));
            case (c)
                0: begin op = 6'h00; fn = r_functs[$urandom_range(0, 13)]; end
                1: op = i_ops[$urandom_range(0, 5)];
                2: op = 6'h23;
                3: op = 6'h2b;
                4: op = b_ops[$urandom_range(0, 3)];
                5: op = 6'h02;
                default: op = 6'h03;
            endcase
            issue(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        issue(6'h0d, 6'h00, 1'b0, TMO, 0);  // reply in the very cycle the limit is hit
        issue(6'h2b, 6'h00, 1'b0, 0, TMO);
        issue(6'h3f, 6'h00, 1'b0, 0, 0);
        do_reset();
        issue(6'h08, 6'h00, 1'b0, 0, 0);
        issue(6'h00, 6'h3f, 1'b0, 0, 0);
        do_reset();
        issue(6'h00, 6'h20, 1'b0, TMO + 1, 0);
        do_reset();
        issue(6'h23, 6'h00, 1'b0, 1, TMO + 1);
        do_reset();
        opcode = 6'h00;
        funct = 6'h20;
        repeat (2) step();
        check("midreq_mem_req_before", int'(mem_req), 1);
        rst_n = 1'b0;
        #1;
        check("midreq_mem_req_async", int'(mem_req), 0);
        check("midreq_reg_we", int'(reg_we), 0);
        step();
        rst_n = 1'b1;
        exp_q.delete();
        issued = 0;
        ev_cnt = 0;
        model_ret = 0;
        #1;
        check("midreq_restart_mem_req", int'(mem_req), 1);
        issue(6'h00, 6'h22, 1'b0, 0, 0);
        repeat (2) step();
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle control sequencer for the MIPS-subset core. It replaces the single-cycle combinational decode with an FSM that shares one memory port and one ALU across the fetch, decode, execute, memory and write-back phases. It drives datapath enables and mux selects, handshakes with the unified memory, retires instructions, and halts on illegal opcodes or memory timeouts.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles per memory request; exceeding it halts the core. Range 1..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]
- cond_true  in  1  ALU compare result (beq/bne/blez/bgtz); sampled in BRANCH
- mem_ready  in  1  memory accepts/completes the current request
- pc_en  out  1  PC register load
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target
- ir_load  out  1  IR load
- mem_req  out  1  memory request
- mem_we  out  1  write qualifier for mem_req
- addr_sel  out  1  0 PC, 1 ALU-out register
- alu_phase  out  2  00 PC+4, 01 branch-target add, 10 execute/address
- reg_we  out  1  register-file write
- wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4
- dst_sel  out  2  00 rt, 01 rd, 10 $31
- instr_done  out  1  one-cycle pulse on an instruction's last cycle
- halted  out  1  sticky until reset
- err_code  out  2  00 none, 01 illegal instruction, 10 memory timeout
- retired  out  CNT_W  retired-instruction count

## Operation
- States: FETCH, DECODE, EXEC, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, HALT.
- FETCH: mem_req=1, addr_sel=0, alu_phase=00. On mem_ready, pulse ir_load and pc_en (pc_src=00), then go to DECODE. Otherwise stay.
- DECODE: alu_phase=01 (branch target precompute). Decode sets the next state:
  - R-type (opcode 000000) with funct in {100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 101011 sltu, 000000 sll, 000010 srl, 000011 sra, 000100 sllv, 000110 srlv, 000111 srav}: go to EXEC.
  - ALU immediates {001000, 001010, 001011, 001100, 001101, 001110}: go to EXEC.
  - lw 100011 and sw 101011: go to MEM_ADDR.
  - beq/bne/blez/bgtz {000100, 000101, 000110, 000111}: go to BRANCH.
  - j 000010 and jal 000011: go to JUMP.
  - Anything else: go to HALT with err_code=01.
- EXEC: alu_phase=10, then WB_ALU.
- WB_ALU: reg_we=1, wb_sel=00. dst_sel=01 for R-type, 00 for immediates. Then FETCH.
- MEM_ADDR: alu_phase=10. Go to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD / MEM_WR: mem_req=1, addr_sel=1, mem_we=1 in MEM_WR only. On mem_ready, go to WB_MEM (lw) or FETCH (sw).
- WB_MEM: reg_we=1, wb_sel=01, dst_sel=00, then FETCH.
- BRANCH: alu_phase=10, pc_src=01, pc_en=cond_true, then FETCH.
- JUMP: pc_en=1, pc_src=10. For jal, also reg_we=1, wb_sel=10, dst_sel=10. Then FETCH.
- HALT: all enables 0. Stays in HALT until rst_n is asserted.
- Every output not listed for a state is 0.

## Timing
- Reset state: FETCH, retired=0, err_code=00, halted=0.
- Every enable is 0 while rst_n is low.
- mem_req rises in the first cycle after reset release.
- State outputs are decoded from the state register (Moore). pc_en in BRANCH depends combinationally on cond_true. FETCH/MEM handshake strobes are qualified by mem_ready in the same cycle.
- Handshake: mem_req, mem_we and addr_sel hold steady until the cycle in which mem_ready=1 is sampled. mem_ready while mem_req=0 is ignored.
- Wait counter: clears on entry to a memory state and increments on each cycle with mem_req=1 and mem_ready=0. If it reaches MEM_TIMEOUT, go to HALT with err_code=10. If mem_ready arrives in the same cycle the counter hits the limit, mem_ready wins.
- Latency at zero wait: R-type/immediate 4 cycles, lw 5, sw 4, branch 3, j/jal 3. Each memory wait cycle adds 1.
- instr_done pulses in: WB_ALU, WB_MEM, BRANCH, JUMP, and in MEM_WR when mem_ready=1.
- retired increments on the same edge as instr_done and wraps modulo 2^CNT_W.
- Reset asserted mid-request: mem_req drops asynchronously and no write-back occurs.

## Structure
- Shared package mc_pkg holds:
  - state enum
  - opcode and funct localparams
  - pc_src, wb_sel, dst_sel, alu_phase and err_code encodings (shared with the datapath muxes)
- One sub-module: mc_decode, a combinational classifier mapping {opcode, funct} to {class, legal}. The FSM, wait counter and retired counter live in mc_sequencer.

## Test plan
- add $3,$1,$2 (0x00221820), mem_ready held high: states FETCH→DECODE→EXEC→WB_ALU; reg_we=1 with dst_sel=01 in cycle 4; instr_done at cycle 4; retired=1.
- lw with mem_ready low for 3 cycles in MEM_RD: mem_req/addr_sel=1 held stable for 4 cycles; WB_MEM follows; total 8 cycles.
- beq, once with cond_true=0 and once with cond_true=1: pc_en=0 and pc_en=1 (pc_src=01) respectively in cycle 3; both retire.
- jal: JUMP cycle asserts pc_en=1, pc_src=10, reg_we=1, wb_sel=10, dst_sel=10.
- Opcode 0x3F, and funct 0x3F under opcode 0: HALT, halted=1, err_code=01, no mem_req afterward, retired unchanged.
- MEM_TIMEOUT=4 with mem_ready never asserted in FETCH: HALT after 4 wait cycles with err_code=10. Then assert rst_n mid-wait in a second run: mem_req=0 immediately; FETCH restarts after release.
